// File: rtl/posit_multiplier.sv
// Posit multiplier: decode both operands, multiply mantissas and add scales,
// normalise, re-encode into a regime/exponent/fraction string, round to
// nearest-even on the bit string, saturate to [minpos, maxpos] and register.
module posit_multiplier #(
  parameter int N  = 8,
  parameter int ES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic [N-1:0] OUT
);

  // Widest fraction field an operand can carry (regime needs at least 2 bits).
  localparam int FW = (N - ES - 3 > 0) ? (N - ES - 3) : 1;
  // Normalised product fraction width (bits below the hidden one).
  localparam int PF = 2 * FW + 1;
  // Signed scale width, covers the sum of two extreme operand scales.
  localparam int SW = $clog2(N) + ES + 3;
  // Extended encode string: 2 regime seed bits, exponent, fraction and
  // N bits of headroom so regime shifting never loses bits off the end.
  localparam int XW = 2 + ES + PF + N;

  localparam logic [N-1:0]          NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [SW-1:0]  K_MAX = SW'(N - 2);
  localparam logic signed [SW-1:0]  K_MIN = -K_MAX;

  typedef struct packed {
    logic          sgn;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
  } dec_t;

  // Split a posit into sign, combined scale k*2^ES+e and fraction bits.
  function automatic dec_t decode(input logic [N-1:0] x);
    dec_t                  d;
    logic [N-2:0]          body;
    logic                  rb;
    logic                  done;
    int                    m;
    logic [ES+FW-1:0]      fields;
    logic signed [SW-1:0]  k;
    body = (N-1)'(x[N-1] ? (~x + N'(1)) : x);
    rb   = body[N-2];
    m    = 0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done) begin
        if (body[i] == rb) m = m + 1;
        else done = 1'b1;
      end
    end
    // Drop regime and terminator; bits missing past the LSB read as zero.
    fields = (ES+FW)'(({body, {(ES+FW){1'b0}}} << (m + 1)) >> (N - 1));
    k = rb ? SW'(m - 1) : SW'(-m);
    d.sgn   = x[N-1];
    d.scale = (k <<< ES) + SW'(fields[ES+FW-1 -: ES]);
    d.frac  = fields[FW-1:0];
    return d;
  endfunction

  // Round to nearest, ties to even, on the N-1 bit magnitude string.
  function automatic logic [N-2:0] round_rne(input logic [N-2:0] mag,
                                             input logic guard,
                                             input logic sticky);
    return mag + (N-1)'(guard & (mag[0] | sticky));
  endfunction

  // Clamp regimes outside the representable range to maxpos / minpos.
  function automatic logic [N-2:0] saturate(input logic signed [SW-1:0] k,
                                            input logic [N-2:0] rounded);
    logic [N-2:0] r;
    r = rounded;
    if (k > K_MAX)      r = {(N-1){1'b1}};
    else if (k < K_MIN) r = (N-1)'(1);
    return r;
  endfunction

  // Build regime/exponent/fraction string for a positive value and round it.
  function automatic logic [N-2:0] encode(input logic signed [SW-1:0] scale,
                                          input logic [PF-1:0] frac);
    logic signed [SW-1:0] k;
    logic [ES-1:0]        e;
    logic [XW-1:0]        pat;
    logic [XW-1:0]        ext;
    k = scale >>> ES;
    e = scale[ES-1:0];
    if (k >= 0) begin
      // Seed "10" then replicate the leading one k more times.
      pat = {2'b10, e, frac, {N{1'b0}}};
      ext = $signed(pat) >>> k;
    end else begin
      // Seed "01" then push in -k-1 more leading zeros.
      pat = {2'b01, e, frac, {N{1'b0}}};
      ext = pat >> (-k - SW'(1));
    end
    return saturate(k, round_rne(ext[XW-1 -: N-1], ext[XW-N], |ext[XW-N-1:0]));
  endfunction

  dec_t                 dec_a;
  dec_t                 dec_b;
  logic [2*FW+1:0]      prod;
  logic signed [SW-1:0] scale_sum;
  logic [PF-1:0]        frac_n;
  logic [N-2:0]         mag;
  logic                 sgn;
  logic [N-1:0]         result;

  // Decode, multiply, normalise, encode and resolve special operands.
  always_comb begin
    dec_a     = decode(IN1);
    dec_b     = decode(IN2);
    prod      = {{(FW+1){1'b0}}, 1'b1, dec_a.frac} * {{(FW+1){1'b0}}, 1'b1, dec_b.frac};
    scale_sum = $signed(dec_a.scale) + $signed(dec_b.scale)
              + $signed({{(SW-1){1'b0}}, prod[2*FW+1]});
    frac_n    = prod[2*FW+1] ? prod[2*FW:0] : {prod[2*FW-1:0], 1'b0};
    mag       = encode(scale_sum, frac_n);
    sgn       = dec_a.sgn ^ dec_b.sgn;
    if (IN1 == NAR || IN2 == NAR)      result = NAR;
    else if (IN1 == '0 || IN2 == '0)   result = '0;
    else if (sgn)                      result = ~{1'b0, mag} + N'(1);
    else                               result = {1'b0, mag};
  end

  // ---- stage boundary: registered product ----
  // Output register, cleared to posit zero while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) OUT <= '0;
    else        OUT <= result;
  end

endmodule

// File: tb/tb_posit_multiplier.sv
// Bench for posit_multiplier: directed values, reset behaviour and random
// pairs checked against a value-domain reference (real arithmetic plus
// nearest-even selection between neighbouring posits).
module tb_posit_multiplier;

  localparam int N    = 8;
  localparam int ES   = 4;
  localparam int MAXP = (1 << (N - 1)) - 1;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [N-1:0] out;

  int total = 0;
  int bad   = 0;
  real vtab [0:MAXP];

  posit_multiplier #(.N(N), .ES(ES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .IN1  (in1),
    .IN2  (in2),
    .OUT  (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int s);
    real r;
    r = 1.0;
    if (s >= 0) for (int i = 0; i < s; i++) r = r * 2.0;
    else        for (int i = 0; i < -s; i++) r = r * 0.5;
    return r;
  endfunction

  // Value of a w-bit posit pattern read straight from the encoding rules.
  function automatic real pval(input int pat_in, input int w);
    int  pat, mask, i, m, k, e, rb;
    bit  neg;
    real f, wgt;
    mask = (1 << w) - 1;
    pat  = pat_in & mask;
    if (pat == 0 || pat == (1 << (w - 1))) return 0.0;
    neg = ((pat >> (w - 1)) & 1) == 1;
    if (neg) pat = ((1 << w) - pat) & mask;
    i  = w - 2;
    rb = (pat >> i) & 1;
    m  = 0;
    while (i >= 0 && ((pat >> i) & 1) == rb) begin
      m++;
      i--;
    end
    k = (rb == 1) ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2 + ((i >= 0) ? ((pat >> i) & 1) : 0);
      i--;
    end
    f   = 1.0;
    wgt = 0.5;
    while (i >= 0) begin
      if (((pat >> i) & 1) == 1) f = f + wgt;
      wgt = wgt * 0.5;
      i--;
    end
    return (neg ? -1.0 : 1.0) * pow2(k * (1 << ES) + e) * f;
  endfunction

  // Reference product: exact real product, then pick the posit it rounds to.
  // The tie point between posits p and p+1 is the (N+1)-bit posit 2p+1.
  function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    real v, mid;
    bit  neg;
    int  p;
    if (a == NAR || b == NAR) return NAR;
    if (a == 0 || b == 0)     return '0;
    v   = pval(int'(a), N) * pval(int'(b), N);
    neg = v < 0.0;
    if (neg) v = -v;
    if (v >= vtab[MAXP])   p = MAXP;
    else if (v <= vtab[1]) p = 1;
    else begin
      p = 1;
      while (p < MAXP && vtab[p + 1] <= v) p++;
      if (vtab[p] != v) begin
        mid = pval(2 * p + 1, N + 1);
        if (v > mid) p++;
        else if (v == mid && (p % 2) == 1) p++;
      end
    end
    return neg ? N'((1 << N) - p) : N'(p);
  endfunction

  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] exp, input string tag);
    @(negedge clk);
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    chk(tag, out, exp);
  endtask

  logic [N-1:0] da [11] = '{8'h40, 8'h48, 8'hC0, 8'hC0, 8'h41, 8'h00, 8'h80, 8'h80, 8'h7F, 8'h01, 8'h81};
  logic [N-1:0] db [11] = '{8'h40, 8'h48, 8'h48, 8'hC0, 8'h41, 8'h5A, 8'h00, 8'h40, 8'h7F, 8'h01, 8'h7F};
  logic [N-1:0] de [11] = '{8'h40, 8'h50, 8'hB8, 8'h40, 8'h42, 8'h00, 8'h80, 8'h80, 8'h7F, 8'h01, 8'h81};

  initial begin
    logic [N-1:0] a, b;
    for (int p = 0; p <= MAXP; p++) vtab[p] = pval(p, N);

    rst_n = 1'b0;
    in1   = 8'h5A;
    in2   = 8'h33;
    #12;
    chk("reset_hold", out, 8'h00);
    @(negedge clk);
    in1   = 8'h40;
    in2   = 8'h40;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", out, 8'h40);

    for (int i = 0; i < 11; i++)
      apply(da[i], db[i], de[i], $sformatf("dir %h*%h", da[i], db[i]));

    // Operands swapped must give the identical word.
    for (int i = 0; i < 11; i++)
      apply(db[i], da[i], de[i], $sformatf("swap %h*%h", db[i], da[i]));

    for (int i = 0; i < 20000; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      apply(a, b, ref_mul(a, b), $sformatf("rnd %h*%h", a, b));
    end

    // Reset asserted mid-stream clears immediately; first edge after release
    // registers whatever is on the inputs.
    @(negedge clk);
    in1 = 8'h48;
    in2 = 8'h48;
    #2 rst_n = 1'b0;
    #1 chk("midrst_async", out, 8'h00);
    @(posedge clk);
    #1 chk("midrst_held", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("midrst_first", out, 8'h50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
